// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: frame sequencer and receiver
// state encodings, plus the default frame start marker.
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CHECK,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, glitch-checked start bit, centre
// sampling, one-cycle rx_valid on a good stop bit or rx_ferr on a bad one.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  rx_state_t        state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;

  // NOTE: every register here uses non-blocking assignment so the order of
  // statements inside the block never changes what the flops capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RX_IDLE;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;

      unique case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            rx_data <= {rx_sync, rx_data[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) rx_valid <= 1'b1;
            else         rx_ferr  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC / length / little-endian words / XOR
// checksum frames from a UART and writes the words into program memory.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         CLK_HZ    = 27000000,
  parameter int         BAUD      = 115200,
  parameter int         ADDR_W    = 13,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [15:0]       mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_uart_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  state_t          state;
  logic [15:0]     word_cnt;
  logic [ADDR_W:0] idx;
  logic [7:0]      len_lo;
  logic [7:0]      data_lo;
  logic [7:0]      csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      idx      <= '0;
      len_lo   <= '0;
      data_lo  <= '0;
      csum     <= '0;
      mem_ce   <= 1'b0;
      mem_ad   <= '0;
      mem_din  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      mem_ce <= 1'b0;

      if (rx_ferr && !(state inside {IDLE, DONE, ERR})) begin
        state <= ERR;
        error <= 1'b1;
      end else if (rx_valid) begin
        unique case (state)
          IDLE, DONE, ERR: begin
            if (rx_data == SYNC_BYTE) begin
              state    <= LEN_LO;
              done     <= 1'b0;
              error    <= 1'b0;
              cpu_hold <= 1'b1;
              idx      <= '0;
              csum     <= '0;
            end
          end
          LEN_LO: begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            word_cnt <= {rx_data, len_lo};
            // A count of exactly 2**ADDR_W fills memory; anything larger cannot fit.
            if ({16'd0, rx_data, len_lo} > (32'd1 << ADDR_W)) begin
              state <= ERR;
              error <= 1'b1;
            end else if ({rx_data, len_lo} == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA_LO;
            end
          end
          DATA_LO: begin
            data_lo <= rx_data;
            csum    <= csum ^ rx_data;
            state   <= DATA_HI;
          end
          DATA_HI: begin
            csum    <= csum ^ rx_data;
            mem_ce  <= 1'b1;
            mem_ad  <= idx[ADDR_W-1:0];
            mem_din <= {rx_data, data_lo};
            idx     <= idx + 1'b1;
            state   <= ((32'(idx) + 32'd1) == {16'd0, word_cnt}) ? CHECK : DATA_LO;
          end
          CHECK: begin
            if (rx_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
